mcu_sequencer: RTL and testbench

MCU_SEQUENCER -- requirements
Module: mcu_sequencer

---
 rtl/mcu_pkg.sv | 42 ++++
 rtl/mcu_sequencer_decode.sv | 49 ++++
 rtl/mcu_sequencer.sv | 148 ++++++++++++++
 tb/tb_mcu_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared opcode, FSM state and ALU-control encodings for the MCU sequencer datapath.
package mcu_pkg;

  localparam int unsigned IR_W  = 8;
  localparam int unsigned OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_ACM  = 3'b000,
    OP_ACMI = 3'b001,
    OP_ADD  = 3'b010,
    OP_NAND = 3'b011,
    OP_BNZ  = 3'b100,
    OP_SLT  = 3'b101,
    OP_SW   = 3'b110,
    OP_LW   = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_NAND = 2'b01,
    ALU_BNZ  = 2'b10,
    ALU_SLT  = 2'b11
  } alu_op_e;

  // Where DECODE hands the instruction next.
  typedef enum logic [1:0] {
    CLS_WB   = 2'd0,
    CLS_EXEC = 2'd1,
    CLS_MEM  = 2'd2
  } next_cls_e;

endpackage

// File: rtl/mcu_sequencer_decode.sv
// Combinational opcode decode: datapath selects, ALU control and the post-DECODE class.
module mcu_decode
  import mcu_pkg::*;
(
  input  logic [2:0] opcode,
  output logic [1:0] cntr_alu,
  output logic       sel_alu_in,
  output logic       sel_acc_in,
  output logic       lw,
  output logic [1:0] next_cls
);

  always_comb begin
    cntr_alu   = ALU_ADD;
    sel_alu_in = 1'b0;
    sel_acc_in = 1'b0;
    lw         = 1'b0;
    next_cls   = CLS_WB;
    case (opcode)
      OP_ACM:  ;
      OP_ACMI: sel_acc_in = 1'b1;
      OP_ADD: begin
        cntr_alu   = ALU_ADD;
        sel_alu_in = 1'b1;
        next_cls   = CLS_EXEC;
      end
      OP_NAND: begin
        cntr_alu   = ALU_NAND;
        sel_alu_in = 1'b1;
        next_cls   = CLS_EXEC;
      end
      OP_BNZ: begin
        cntr_alu = ALU_BNZ;
        next_cls = CLS_EXEC;
      end
      OP_SLT: begin
        cntr_alu   = ALU_SLT;
        sel_alu_in = 1'b1;
        next_cls   = CLS_EXEC;
      end
      OP_SW:   next_cls = CLS_MEM;
      OP_LW: begin
        lw       = 1'b1;
        next_cls = CLS_MEM;
      end
    endcase
  end

endmodule

// File: rtl/mcu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/writeback control with
// ack timeouts and a retired-instruction counter.
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned RET_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             im_req,
  input  logic             im_ack,
  input  logic [7:0]       im_data,
  output logic             dm_req,
  output logic             dm_we,
  input  logic             dm_ack,
  input  logic             alu_nz,
  output logic [7:0]       ir,
  output logic [1:0]       cntr_alu,
  output logic             sel_alu_in,
  output logic             sel_acc_in,
  output logic             lw,
  output logic             reg_we,
  output logic             acc_we,
  output logic             pc_en,
  output logic             pc_sel_br,
  output logic             busy,
  output logic             error,
  output logic [RET_W-1:0] retired
);

  localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);

  state_e            state;
  state_e            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              br_flag;
  logic [2:0]        opcode;
  logic [1:0]        dec_cls;
  logic              in_handshake;
  logic              ack_hit;
  logic              ack_expired;

  assign opcode = ir[7:5];

  // Selects follow the latched instruction, so they stay put until the next fetch lands.
  mcu_decode u_decode (
    .opcode     (opcode),
    .cntr_alu   (cntr_alu),
    .sel_alu_in (sel_alu_in),
    .sel_acc_in (sel_acc_in),
    .lw         (lw),
    .next_cls   (dec_cls)
  );

  always_comb begin
    in_handshake = (state == ST_FETCH) || (state == ST_MEM);
    ack_hit      = ((state == ST_FETCH) && im_ack) || ((state == ST_MEM) && dm_ack);
    ack_expired  = in_handshake && !ack_hit && (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (run) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (ack_expired) state_nxt = ST_ERR;
        else if (im_ack) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        case (dec_cls)
          CLS_EXEC: state_nxt = ST_EXEC;
          CLS_MEM:  state_nxt = ST_MEM;
          default:  state_nxt = ST_WB;
        endcase
      end
      ST_EXEC:   state_nxt = ST_WB;
      ST_MEM: begin
        if (ack_expired)          state_nxt = ST_ERR;
        else if (dm_ack) begin
          if (opcode == OP_LW)    state_nxt = ST_WB;
          else                    state_nxt = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_WB:     state_nxt = run ? ST_FETCH : ST_IDLE;
      ST_ERR:    state_nxt = ST_ERR;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Requests and strobes; a store retires in its acknowledge cycle instead of in WB.
  always_comb begin
    im_req    = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    reg_we    = 1'b0;
    acc_we    = 1'b0;
    pc_en     = 1'b0;
    pc_sel_br = 1'b0;
    busy      = (state != ST_IDLE) && (state != ST_ERR);
    error     = (state == ST_ERR);
    case (state)
      ST_FETCH: im_req = 1'b1;
      ST_MEM: begin
        dm_req = 1'b1;
        dm_we  = (opcode == OP_SW);
        pc_en  = dm_ack && (opcode == OP_SW);
      end
      ST_WB: begin
        pc_en     = 1'b1;
        reg_we    = (opcode == OP_ADD) || (opcode == OP_NAND) ||
                    (opcode == OP_SLT) || (opcode == OP_LW);
        acc_we    = (opcode == OP_ACM) || (opcode == OP_ACMI);
        pc_sel_br = (opcode == OP_BNZ) && br_flag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir      <= '0;
      br_flag <= 1'b0;
    end else begin
      if ((state == ST_FETCH) && im_ack) ir <= im_data;
      if (state == ST_EXEC) br_flag <= (opcode == OP_BNZ) && alu_nz;
    end
  end

  // Wait counter runs only while a request is outstanding and freezes in ERR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wait_cnt <= '0;
    else if (in_handshake)    wait_cnt <= ack_hit ? '0 : wait_cnt + WAIT_W'(1);
    else if (state != ST_ERR) wait_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        retired <= '0;
    else if (pc_en) retired <= retired + RET_W'(1);
  end

endmodule

// File: tb/tb_mcu_sequencer.sv
// Scoreboard bench for mcu_sequencer: stimulus pushes expected retirements, a negedge
// monitor pops them on every pc_en and also evaluates posted directed checks.
module tb_mcu_sequencer;

  localparam int unsigned RET_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             im_req;
  logic             im_ack;
  logic [7:0]       im_data;
  logic             dm_req;
  logic             dm_we;
  logic             dm_ack;
  logic             alu_nz;
  logic [7:0]       ir;
  logic [1:0]       cntr_alu;
  logic             sel_alu_in;
  logic             sel_acc_in;
  logic             lw;
  logic             reg_we;
  logic             acc_we;
  logic             pc_en;
  logic             pc_sel_br;
  logic             busy;
  logic             error;
  logic [RET_W-1:0] retired;

  mcu_sequencer #(.ACK_TIMEOUT(15), .RET_W(RET_W)) dut (
    .clk(clk), .rst(rst), .run(run),
    .im_req(im_req), .im_ack(im_ack), .im_data(im_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_ack(dm_ack),
    .alu_nz(alu_nz), .ir(ir), .cntr_alu(cntr_alu),
    .sel_alu_in(sel_alu_in), .sel_acc_in(sel_acc_in), .lw(lw),
    .reg_we(reg_we), .acc_we(acc_we), .pc_en(pc_en), .pc_sel_br(pc_sel_br),
    .busy(busy), .error(error), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op; int reg_we; int acc_we; int br; int lat; int dmwe;
    int alu; int alu_chk; int sel_alu; int sel_acc; int lw;
  } exp_t;

  typedef struct {
    string name; int act; int req;
  } post_t;

  exp_t  exp_q[$];
  post_t post_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    tot_reg  = 0;

  // Expected retirement record from the instruction-set rules.
  function automatic exp_t model(input logic [7:0] instr, input int im_w, input int dm_w,
                                 input bit nz);
    exp_t e;
    int   op;
    op        = int'(instr[7:5]);
    e.op      = op;
    e.reg_we  = (op inside {2, 3, 5, 7}) ? 1 : 0;
    e.acc_we  = (op inside {0, 1}) ? 1 : 0;
    e.br      = (op == 4 && nz) ? 1 : 0;
    e.lat     = 3 + ((op inside {2, 3, 4, 5, 7}) ? 1 : 0) + im_w + ((op >= 6) ? dm_w : 0);
    e.dmwe    = (op == 6) ? dm_w + 1 : 0;
    e.alu_chk = (op >= 2 && op <= 5) ? 1 : 0;
    e.alu     = (op >= 2 && op <= 5) ? op - 2 : 0;
    e.sel_alu = (op inside {2, 3, 5}) ? 1 : 0;
    e.sel_acc = (op == 1) ? 1 : 0;
    e.lw      = (op == 7) ? 1 : 0;
    return e;
  endfunction

  function automatic void chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  int in_instr = 0, start = 0, reg_cnt = 0, acc_cnt = 0, dmwe_cnt = 0, exp_ret = 0;

  always @(negedge clk) begin
    post_t p;
    exp_t  e;
    cyc++;
    while (post_q.size() > 0) begin
      p = post_q.pop_front();
      chk(p.name, p.act, p.req);
    end
    if (rst) begin
      in_instr = 0; reg_cnt = 0; acc_cnt = 0; dmwe_cnt = 0; exp_ret = 0;
    end else begin
      if (im_req && in_instr == 0) begin
        in_instr = 1;
        start    = cyc;
      end
      reg_cnt  += int'(reg_we);
      acc_cnt  += int'(acc_we);
      dmwe_cnt += int'(dm_req && dm_we);
      if (pc_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("opcode",     int'(ir[7:5]),   e.op);
          chk("latency",    cyc - start + 1, e.lat);
          chk("reg_we_cnt", reg_cnt,         e.reg_we);
          chk("acc_we_cnt", acc_cnt,         e.acc_we);
          chk("dm_we_cnt",  dmwe_cnt,        e.dmwe);
          chk("pc_sel_br",  int'(pc_sel_br), e.br);
          chk("sel_alu_in", int'(sel_alu_in), e.sel_alu);
          chk("sel_acc_in", int'(sel_acc_in), e.sel_acc);
          chk("lw",         int'(lw),        e.lw);
          if (e.alu_chk != 0) chk("cntr_alu", int'(cntr_alu), e.alu);
        end
        chk("retired", int'(retired), exp_ret);
        exp_ret  = (exp_ret + 1) % (1 << RET_W);
        in_instr = 0; reg_cnt = 0; acc_cnt = 0; dmwe_cnt = 0;
      end
    end
  end

  always @(negedge clk) if (reg_we) tot_reg++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input string n, input int a, input int r);
    post_t p;
    p.name = n; p.act = a; p.req = r;
    post_q.push_back(p);
  endtask

  // Serves one instruction's handshakes with the given ack delays; ends after its retirement.
  task automatic run_instr(input logic [7:0] instr, input int im_w, input int dm_w,
                           input bit nz, input bit drop_run);
    int iw = 0, dw = 0, k = -1;
    bit fetched = 0, done = 0;
    exp_q.push_back(model(instr, im_w, dm_w, nz));
    for (int c = 0; c < 80 && !done; c++) begin
      im_ack = 1'b0;
      dm_ack = 1'b0;
      if (fetched) k++;
      alu_nz = (k == 1) ? nz : ~nz;
      if (drop_run && k == 1) run = 1'b0;
      if (im_req && !fetched) begin
        if (iw == im_w) begin
          im_ack  = 1'b1;
          im_data = instr;
          fetched = 1'b1;
        end else begin
          iw++;
          im_data = 8'($urandom);
        end
      end
      if (dm_req) begin
        if (dw == dm_w) dm_ack = 1'b1;
        else            dw++;
      end
      @(negedge clk);
      if (pc_en) done = 1'b1;
      step();
    end
    im_ack = 1'b0;
    dm_ack = 1'b0;
    if (!done) post("instr_timeout", 0, 1);
  endtask

  task automatic fetch_one(input logic [7:0] instr);
    for (int c = 0; c < 6 && !im_req; c++) step();
    post("fetch_req", int'(im_req), 1);
    im_ack  = 1'b1;
    im_data = instr;
    step();
    im_ack  = 1'b0;
  endtask

  initial begin
    int tot0;
    rst = 1'b0; run = 1'b0; im_ack = 1'b0; im_data = '0; dm_ack = 1'b0; alu_nz = 1'b0;
    #2 rst = 1'b1;
    step();
    post("rst_im_req", int'(im_req), 0);
    post("rst_dm_req", int'(dm_req), 0);
    post("rst_busy",   int'(busy),   0);
    post("rst_error",  int'(error),  0);
    post("rst_retired", int'(retired), 0);
    post("rst_ir",     int'(ir),     0);
    post("rst_cntr_alu", int'(cntr_alu), 0);
    post("rst_strobes", int'({reg_we, acc_we, pc_en, dm_we, pc_sel_br}), 0);
    post("rst_selects", int'({sel_alu_in, sel_acc_in, lw}), 0);
    step();
    rst = 1'b0;
    step(); step();
    post("idle_busy", int'(busy), 0);
    post("idle_im_req", int'(im_req), 0);

    run = 1'b1;
    run_instr(8'h21, 0, 0, 1'b0, 1'b0);
    run_instr(8'h42, 0, 0, 1'b0, 1'b0);
    run_instr(8'h63, 0, 0, 1'b0, 1'b0);
    run_instr(8'hA4, 0, 0, 1'b0, 1'b0);
    post("retired_after_prog", int'(retired), 4);

    run_instr(8'h81, 0, 0, 1'b1, 1'b0);
    run_instr(8'h81, 0, 0, 1'b0, 1'b0);
    run_instr(8'hC5, 0, 3, 1'b0, 1'b0);
    run_instr(8'hE5, 2, 14, 1'b0, 1'b0);
    run_instr(8'h42, 14, 0, 1'b0, 1'b0);
    post("no_error_at_boundary", int'(error), 0);

    for (int i = 0; i < 40; i++)
      run_instr(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 5),
                1'($urandom), 1'b0);

    run_instr(8'h42, 1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      post("idle_after_drop", int'({busy, im_req}), 0);
      step();
    end

    run = 1'b1;
    fetch_one(8'hE5);
    step();
    repeat (14) step();
    post("dm_req_before_timeout", int'(dm_req), 1);
    post("error_before_timeout", int'(error), 0);
    step();
    post("timeout_error", int'(error), 1);
    post("timeout_busy",  int'(busy),  0);
    post("timeout_reqs",  int'({im_req, dm_req, pc_en, reg_we}), 0);
    dm_ack = 1'b1;
    repeat (3) step();
    dm_ack = 1'b0;
    post("err_sticky", int'(error), 1);
    post("err_no_req", int'({im_req, dm_req}), 0);
    rst = 1'b1;
    #1;
    post("err_rst_error",   int'(error),   0);
    post("err_rst_retired", int'(retired), 0);
    step();
    rst = 1'b0;
    step();

    tot0 = tot_reg;
    fetch_one(8'hE5);
    step();
    step();
    post("lw_mem_req", int'(dm_req), 1);
    #2 rst = 1'b1;
    #1;
    post("rst_mid_mem_dm_req", int'(dm_req), 0);
    post("rst_mid_mem_reg_we", int'(reg_we), 0);
    step(); step();
    rst = 1'b0;
    run = 1'b0;
    step(); step();
    post("rst_mid_mem_no_reg_we", tot_reg - tot0, 0);
    post("rst_mid_mem_retired", int'(retired), 0);

    run = 1'b1;
    run_instr(8'h01, 0, 0, 1'b0, 1'b0);
    run = 1'b0;
    post("retired_after_recover", int'(retired), 1);
    step();
    post("scoreboard_empty", exp_q.size(), 0);
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
